// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU between two requesters.
//   Port 0 is the CPU execute stage, port 1 the auxiliary/debug engine.
//   Round-robin arbitration in IDLE; the owner's opcode/operands are
//   latched onto the ALU interface and held stable until the response.
//   The ALU done handshake is followed (done falls, then rises again).
//   Result and flags are captured and returned with a one-cycle valid
//   pulse to the owner. Opcodes CFG_LO..CFG_HI are config ops: the ALU
//   is not started and the response carries result = 0, flags = 0.
//
// Optional feature (macro ALU_WDT_EN): a watchdog counts cycles spent
//   waiting on the ALU. At TIMEOUT it responds with result = 8'hFF,
//   flags = 0 and sets the sticky err flag. Without the macro err is
//   tied low and the controller waits indefinitely.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req0/1, op0/1, a0/1, b0/1, cin0/1  requester inputs
//   gnt0/1, valid0/1                grant level, response pulse
//   result, carry, over, zero       shared captured response
//   err                             watchdog error (sticky)
//   alu_start, alu_cins, alu_a, alu_b, alu_carryin, alu_oe  ALU drive
//   alu_done, alu_out, alu_carryout, alu_overout           ALU return
module alu_arbiter #(
    parameter logic [7:0]  CFG_LO  = 8'h40,
    parameter logic [7:0]  CFG_HI  = 8'h44,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] op0,
    input  logic [7:0] op1,
    input  logic [7:0] a0,
    input  logic [7:0] a1,
    input  logic [7:0] b0,
    input  logic [7:0] b1,
    input  logic       cin0,
    input  logic       cin1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       valid0,
    output logic       valid1,
    output logic [7:0] result,
    output logic       carry,
    output logic       over,
    output logic       zero,
    output logic       err,
    output logic       alu_start,
    output logic [7:0] alu_cins,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_carryin,
    output logic       alu_oe,
    input  logic       alu_done,
    input  logic [7:0] alu_out,
    input  logic       alu_carryout,
    input  logic       alu_overout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        CFG     = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t     state;
    logic       owner;      // 0 = port 0, 1 = port 1
    logic       last;       // most recently granted port
    logic       pick;
    logic [7:0] op_sel;
    logic [7:0] a_sel;
    logic [7:0] b_sel;
    logic       cin_sel;
    logic       is_cfg;
    logic       in_wait;
    logic       wdt_hit;
    logic       to_resp;

    // Winner of a new arbitration: on a tie the port that did not go last.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else begin
            pick = req1;
        end
    end

    // Operand mux driven by the registered owner.
    always_comb begin
        op_sel  = owner ? op1  : op0;
        a_sel   = owner ? a1   : a0;
        b_sel   = owner ? b1   : b0;
        cin_sel = owner ? cin1 : cin0;
        is_cfg  = (op_sel >= CFG_LO) && (op_sel <= CFG_HI);
    end

    assign in_wait = (state == WAIT_LO) || (state == WAIT_HI);

`ifdef ALU_WDT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wdt_cnt;

    // Watchdog: cleared on grant, counts every cycle spent waiting on the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt <= '0;
        end else if (state == GRANT) begin
            wdt_cnt <= '0;
        end else if (in_wait) begin
            wdt_cnt <= wdt_cnt + CNT_W'(1);
        end
    end

    assign wdt_hit = in_wait && (wdt_cnt == CNT_W'(TIMEOUT - 1));

    // Sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (wdt_hit) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign wdt_hit        = 1'b0;
    assign err            = 1'b0;
`endif

    // Conditions that finish the current operation this cycle.
    assign to_resp = (state == CFG) || wdt_hit ||
                     ((state == WAIT_HI) && alu_done);

    // Controller: state, grants, ALU drive and captured response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            valid0      <= 1'b0;
            valid1      <= 1'b0;
            result      <= 8'h00;
            carry       <= 1'b0;
            over        <= 1'b0;
            zero        <= 1'b0;
            alu_start   <= 1'b0;
            alu_cins    <= 8'h00;
            alu_a       <= 8'h00;
            alu_b       <= 8'h00;
            alu_carryin <= 1'b0;
            alu_oe      <= 1'b0;
        end else begin
            valid0    <= 1'b0;
            valid1    <= 1'b0;
            alu_start <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= pick;
                        last  <= pick;
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    alu_cins    <= op_sel;
                    alu_a       <= a_sel;
                    alu_b       <= b_sel;
                    alu_carryin <= cin_sel;
                    if (is_cfg) begin
                        state <= CFG;
                    end else begin
                        alu_start <= 1'b1;
                        state     <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    // The ALU acknowledges start by dropping done.
                    if (!alu_done) begin
                        alu_oe <= 1'b1;
                        state  <= WAIT_HI;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= state;
                end
            endcase

            // Completion overrides the per-state updates above.
            if (to_resp) begin
                state       <= RESP;
                valid0      <= ~owner;
                valid1      <= owner;
                gnt0        <= 1'b0;
                gnt1        <= 1'b0;
                alu_oe      <= 1'b0;
                alu_cins    <= 8'h00;
                alu_a       <= 8'h00;
                alu_b       <= 8'h00;
                alu_carryin <= 1'b0;
                if (state == CFG) begin
                    result <= 8'h00;
                    carry  <= 1'b0;
                    over   <= 1'b0;
                    zero   <= 1'b0;
                end else if (wdt_hit) begin
                    result <= 8'hFF;
                    carry  <= 1'b0;
                    over   <= 1'b0;
                    zero   <= 1'b0;
                end else begin
                    result <= alu_out;
                    carry  <= alu_carryout;
                    over   <= alu_overout;
                    zero   <= (alu_out == 8'h00);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU stub with a 6-cycle busy window, randomized
// single and contended transactions checked against a transaction-level
// model (expected result per op, round-robin winner, end-to-end latency).
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] op0 = 8'h00, op1 = 8'h00;
    logic [7:0] a0 = 8'h00, a1 = 8'h00, b0 = 8'h00, b1 = 8'h00;
    logic       cin0 = 1'b0, cin1 = 1'b0;
    logic       gnt0, gnt1, valid0, valid1;
    logic [7:0] result;
    logic       carry, over, zero, err;
    logic       alu_start, alu_carryin, alu_oe;
    logic [7:0] alu_cins, alu_a, alu_b;
    logic       alu_done = 1'b1;
    logic [7:0] alu_out;
    logic       alu_carryout, alu_overout;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .cin0(cin0), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
        .result(result), .carry(carry), .over(over), .zero(zero), .err(err),
        .alu_start(alu_start), .alu_cins(alu_cins), .alu_a(alu_a), .alu_b(alu_b),
        .alu_carryin(alu_carryin), .alu_oe(alu_oe), .alu_done(alu_done),
        .alu_out(alu_out), .alu_carryout(alu_carryout), .alu_overout(alu_overout)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic ref_last = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {over, carry, result[7:0]} of the ALU operation.
    function automatic logic [9:0] alu_ref(input logic [7:0] op, a, b, input logic c);
        logic [8:0] s;
        logic o;
        s = 9'd0;
        o = 1'b0;
        case (op)
            8'h10: begin
                s = {1'b0, a} + {1'b0, b} + {8'd0, c};
                o = (a[7] == b[7]) && (s[7] != a[7]);
            end
            8'h11: begin
                s = {1'b0, a} - {1'b0, b};
                o = (a[7] != b[7]) && (s[7] != a[7]);
            end
            8'h12:   s = {1'b0, a & b};
            8'h13:   s = {1'b0, a | b};
            default: s = {1'b0, a ^ b};
        endcase
        return {o, s};
    endfunction

    function automatic logic is_cfg_op(input logic [7:0] op);
        return (op >= 8'h40) && (op <= 8'h44);
    endfunction

    // Expected response {zero, over, carry, result}.
    function automatic logic [10:0] exp_resp(input logic [7:0] op, a, b, input logic c);
        logic [9:0] r;
        if (is_cfg_op(op)) return 11'd0;
        r = alu_ref(op, a, b, c);
        return {(r[7:0] == 8'h00), r};
    endfunction

    function automatic int exp_lat(input logic [7:0] op);
        return is_cfg_op(op) ? 3 : 10;
    endfunction

    function automatic logic [7:0] rand_op();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 4) return 8'h10 + 8'(r);
        if (r == 5) return 8'h40 + 8'($urandom_range(0, 4));
        if (r == 6) return 8'h3F;
        if (r == 7) return 8'h45;
        return 8'h10;
    endfunction

    // ALU stub: done falls the cycle after start, stays low 6 cycles.
    logic       stuck = 1'b0;
    logic [9:0] pend = 10'd0;
    logic [9:0] out_q = 10'd0;
    int         bcnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_done <= 1'b1;
            out_q    <= 10'd0;
            bcnt     <= 0;
        end else if (alu_done) begin
            if (alu_start && !stuck) begin
                alu_done <= 1'b0;
                bcnt     <= 5;
                pend     <= alu_ref(alu_cins, alu_a, alu_b, alu_carryin);
            end
        end else if (bcnt == 0) begin
            alu_done <= 1'b1;
            out_q    <= pend;
        end else begin
            bcnt <= bcnt - 1;
        end
    end

    assign alu_out      = alu_oe ? out_q[7:0] : 8'h00;
    assign alu_carryout = alu_oe ? out_q[8]   : 1'b0;
    assign alu_overout  = alu_oe ? out_q[9]   : 1'b0;

    // Activity counters sampled away from the active edge.
    int starts = 0, overlap = 0, cins_cyc = 0, g0_cyc = 0, g1_cyc = 0;
    always @(negedge clk) begin
        if (alu_start) starts++;
        if (gnt0 && gnt1) overlap++;
        if (alu_cins != 8'h00) cins_cyc++;
        if (gnt0) g0_cyc++;
        if (gnt1) g1_cyc++;
    end

    task automatic drive(input int p, input logic [7:0] op, a, b, input logic c, input logic rq);
        if (p == 0) begin
            op0 = op; a0 = a; b0 = b; cin0 = c; req0 = rq;
        end else begin
            op1 = op; a1 = a; b1 = b; cin1 = c; req1 = rq;
        end
    endtask

    task automatic check_resp(input string tag, input logic [10:0] e);
        check({tag, "_result"}, 32'(result), 32'(e[7:0]));
        check({tag, "_flags"}, 32'({zero, over, carry}), 32'({e[10], e[9], e[8]}));
    endtask

    task automatic run_single(input int p, input logic [7:0] op, a, b, input logic c);
        int cyc, s0, c0, go0, wrong;
        logic seen;
        s0 = starts; c0 = cins_cyc; go0 = (p == 0) ? g1_cyc : g0_cyc;
        cyc = 0; wrong = 0; seen = 1'b0;
        @(negedge clk);
        drive(p, op, a, b, c, 1'b1);
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if ((p == 0) ? valid0 : valid1) seen = 1'b1;
            if ((p == 0) ? valid1 : valid0) wrong++;
        end
        drive(p, op, a, b, c, 1'b0);
        check("single_valid", 32'(seen), 32'd1);
        check("single_latency", 32'(cyc), 32'(exp_lat(op)));
        check_resp("single", exp_resp(op, a, b, c));
        check("single_wrong_valid", 32'(wrong), 32'd0);
        check("single_starts", 32'(starts - s0), is_cfg_op(op) ? 32'd0 : 32'd1);
        check("single_cins_cycles", 32'(cins_cyc - c0), is_cfg_op(op) ? 32'd1 : 32'd8);
        check("single_other_gnt", 32'(((p == 0) ? g1_cyc : g0_cyc) - go0), 32'd0);
        ref_last = 1'(p);
    endtask

    // Both ports request together; loser is served right after the winner.
    task automatic run_dual(input logic [7:0] opx0, ax0, bx0, input logic cx0,
                            input logic [7:0] opx1, ax1, bx1, input logic cx1);
        int cyc, t0, t1, first, ov0;
        int lat[2];
        t0 = 0; t1 = 0; cyc = 0; ov0 = overlap;
        first = ref_last ? 0 : 1;
        lat[0] = exp_lat(opx0);
        lat[1] = exp_lat(opx1);
        @(negedge clk);
        drive(0, opx0, ax0, bx0, cx0, 1'b1);
        drive(1, opx1, ax1, bx1, cx1, 1'b1);
        while ((t0 == 0 || t1 == 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (valid0 && t0 == 0) begin
                t0 = cyc;
                check_resp("dual0", exp_resp(opx0, ax0, bx0, cx0));
                req0 = 1'b0;
            end
            if (valid1 && t1 == 0) begin
                t1 = cyc;
                check_resp("dual1", exp_resp(opx1, ax1, bx1, cx1));
                req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        if (first == 0) begin
            check("dual_first_lat", 32'(t0), 32'(lat[0]));
            check("dual_second_lat", 32'(t1), 32'(lat[0] + 1 + lat[1]));
        end else begin
            check("dual_first_lat", 32'(t1), 32'(lat[1]));
            check("dual_second_lat", 32'(t0), 32'(lat[1] + 1 + lat[0]));
        end
        check("dual_overlap", 32'(overlap - ov0), 32'd0);
        ref_last = (first == 0) ? 1'b1 : 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_last = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int k, cyc, s0, ov0, vcnt;
        int order[4];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("rst_valid", 32'({valid0, valid1}), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags_err", 32'({carry, over, zero, err}), 32'd0);
        check("rst_alu", 32'({alu_start, alu_oe, alu_carryin, alu_cins, alu_a, alu_b}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_single(0, 8'h10, 8'h05, 8'h03, 1'b0);
        run_single(1, 8'h10, 8'hFF, 8'h01, 1'b0);
        run_single(0, 8'h42, 8'h12, 8'h34, 1'b1);
        run_single(1, 8'h40, 8'h00, 8'h00, 1'b0);
        run_single(0, 8'h44, 8'h01, 8'h01, 1'b0);
        run_single(0, 8'h10, 8'h7F, 8'h01, 1'b0);

        // Contention from reset: both held for 4 operations
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 8'h10, 8'h01, 8'h02, 1'b0, 1'b1);
        drive(1, 8'h10, 8'h03, 8'h04, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        s0 = starts; ov0 = overlap;
        rst_n = 1'b1;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (valid0 && valid1) check("cont_both_valid", 32'd1, 32'd0);
            if (valid0) begin
                order[k] = 0; k++;
                check_resp("cont0", exp_resp(8'h10, 8'h01, 8'h02, 1'b0));
            end else if (valid1) begin
                order[k] = 1; k++;
                check_resp("cont1", exp_resp(8'h10, 8'h03, 8'h04, 1'b0));
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("cont_count", 32'(k), 32'd4);
        for (int i = 0; i < k; i++) check("cont_order", 32'(order[i]), 32'(i % 2));
        repeat (3) @(negedge clk);
        check("cont_starts", 32'(starts - s0), 32'd4);
        check("cont_overlap", 32'(overlap - ov0), 32'd0);
        ref_last = 1'b1;

        // Randomized single and contended traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_dual(rand_op(), 8'($urandom), 8'($urandom), 1'($urandom),
                         rand_op(), 8'($urandom), 8'($urandom), 1'($urandom));
            end else begin
                run_single(int'($urandom_range(0, 1)), rand_op(), 8'($urandom),
                           8'($urandom), 1'($urandom));
            end
        end

        // Mid-operation reset
        @(negedge clk);
        drive(0, 8'h10, 8'h21, 8'h22, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("midrst_alu", 32'({alu_start, alu_oe, alu_cins}), 32'd0);
        check("midrst_resp", 32'({valid0, valid1, result, carry, over, zero}), 32'd0);
        req0 = 1'b0;
        vcnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (valid0 || valid1) vcnt++;
        end
        rst_n = 1'b1;
        ref_last = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (valid0 || valid1) vcnt++;
        end
        check("midrst_no_valid", 32'(vcnt), 32'd0);
        run_single(0, 8'h10, 8'h0A, 8'h0B, 1'b1);

        // ALU that never acknowledges start
        stuck = 1'b1;
        @(negedge clk);
        drive(0, 8'h10, 8'h01, 8'h01, 1'b0, 1'b1);
        vcnt = 0;
        for (int i = 0; i < 80 && vcnt == 0; i++) begin
            @(negedge clk);
            if (valid0) vcnt++;
        end
        req0 = 1'b0;
`ifdef ALU_WDT_EN
        check("wdt_valid", 32'(vcnt), 32'd1);
        check_resp("wdt", {3'b000, 8'hFF});
        check("wdt_err", 32'(err), 32'd1);
        stuck = 1'b0;
        run_single(1, 8'h11, 8'h10, 8'h20, 1'b0);
        check("wdt_err_sticky", 32'(err), 32'd1);
        apply_reset();
        check("wdt_err_cleared", 32'(err), 32'd0);
`else
        check("nowdt_valid", 32'(vcnt), 32'd0);
        check("nowdt_err", 32'(err), 32'd0);
        stuck = 1'b0;
        apply_reset();
`endif
        run_single(1, 8'h13, 8'hA5, 8'h5A, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
